// File: rtl/bg_sdram_sched.sv
// bg_sdram_sched: shares one SDRAM channel between the HPS download
// writer and the display-rate background pixel prefetcher.
module bg_sdram_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              sdram_present,
  input  logic              ce_pix,
  input  logic              de,
  input  logic              vs,
  output logic              mem_req,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  input  logic [31:0]       mem_dout,
  output logic              use_bg,
  output logic [31:0]       pix_out,
  output logic              underrun,
  output logic              wr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH = FIFO_DEPTH[AW:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]        r_state;
  logic              r_req;
  logic              r_rnw;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_din;
  logic [7:0]        r_lo;
  logic              r_wpend_v;
  logic [ADDR_W-1:0] r_wpend_addr;
  logic [15:0]       r_wpend_data;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_use_bg;
  logic              r_vs_prev;
  logic [31:0]       r_pix;
  logic              r_underrun;
  logic              r_ovf;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_count;

  logic w_restart;
  logic w_ack;
  logic w_wack;
  logic w_rack;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_pop_ok;
  logic w_word;
  logic w_wfree;
  logic w_space;
  logic w_rd_go;

  assign w_restart = ce_pix & vs & ~r_vs_prev;
  // Acks only count while a request is in flight; IDLE ignores stray ones.
  assign w_ack     = mem_ack & (r_state != S_IDLE);
  assign w_wack    = w_ack & (r_state == S_WRITE);
  assign w_rack    = w_ack & (r_state == S_READ);
  assign w_push    = w_rack & ~w_restart;
  assign w_pop     = ce_pix & de & r_use_bg;
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = w_pop & ~w_empty;
  assign w_word    = dl_wr & dl_addr[0];
  assign w_wfree   = ~r_wpend_v | w_wack;
  assign w_space   = w_restart | (r_count < LP_DEPTH);
  assign w_rd_go   = r_use_bg & ~dl_active & w_space;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_wpend_v) begin
            r_state <= S_WRITE;
            r_req   <= 1'b1;
            r_rnw   <= 1'b0;
            r_addr  <= r_wpend_addr;
            r_din   <= r_wpend_data;
          end else if (w_rd_go) begin
            r_state <= S_READ;
            r_req   <= 1'b1;
            r_rnw   <= 1'b1;
            r_addr  <= w_restart ? '0 : r_raddr;
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        S_READ: begin
          if (w_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else if (w_restart) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_lo         <= '0;
      r_wpend_v    <= 1'b0;
      r_wpend_addr <= '0;
      r_wpend_data <= '0;
      r_ovf        <= 1'b0;
      r_use_bg     <= 1'b0;
    end else begin
      if (dl_wr && !dl_addr[0]) begin
        r_lo <= dl_data;
      end
      if (w_word && w_wfree) begin
        r_wpend_v    <= 1'b1;
        r_wpend_addr <= ADDR_W'(dl_addr[24:1]);
        r_wpend_data <= {dl_data, r_lo};
      end else if (w_wack) begin
        r_wpend_v    <= 1'b0;
      end
      if (w_word && !w_wfree) begin
        r_ovf <= 1'b1;
      end
      if (dl_wr && dl_active && sdram_present) begin
        r_use_bg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_fifo[r_wp] <= mem_dout;
    end
  end

  // A pop in the restart cycle still sees the old contents.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_raddr    <= '0;
      r_vs_prev  <= 1'b0;
      r_pix      <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (ce_pix) begin
        r_vs_prev <= vs;
      end
      if (w_restart) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= '0;
        r_raddr <= '0;
      end else begin
        if (w_push) begin
          r_wp    <= r_wp + 1'b1;
          r_raddr <= r_raddr + ADDR_W'(2);
        end
        if (w_pop_ok) begin
          r_rp <= r_rp + 1'b1;
        end
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop_ok);
      end
      if (w_pop) begin
        if (w_empty) begin
          r_pix      <= '0;
          r_underrun <= 1'b1;
        end else begin
          r_pix      <= r_fifo[r_rp];
        end
      end
    end
  end

  assign mem_req     = r_req;
  assign mem_rnw     = r_rnw;
  assign mem_addr    = r_addr;
  assign mem_din     = r_din;
  assign use_bg      = r_use_bg;
  assign pix_out     = r_pix;
  assign underrun    = r_underrun;
  assign wr_overflow = r_ovf;

endmodule

// File: tb/tb_bg_sdram_sched.sv
// tb_bg_sdram_sched: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the scheduler.
module tb_bg_sdram_sched;

  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        sdram_present;
  logic        ce_pix;
  logic        de;
  logic        vs;
  logic        mem_req;
  logic        mem_rnw;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic [31:0] mem_dout;
  logic        use_bg;
  logic [31:0] pix_out;
  logic        underrun;
  logic        wr_overflow;

  bg_sdram_sched #(.FIFO_DEPTH(DEPTH), .ADDR_W(24)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .sdram_present(sdram_present),
    .ce_pix(ce_pix), .de(de), .vs(vs),
    .mem_req(mem_req), .mem_rnw(mem_rnw),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout),
    .use_bg(use_bg), .pix_out(pix_out),
    .underrun(underrun), .wr_overflow(wr_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  // memory responder controls and logs
  bit          ack_en = 0;
  int          lat = 3;
  int          wcnt = 0;
  logic [23:0] rd_a[$];
  logic [31:0] rd_d[$];

  // model state: txn 0 none, 1 write, 2 read, 3 read being discarded
  int          m_txn;
  logic        m_req, m_rnw, m_use, m_und, m_ovf, m_vsp, m_wv;
  logic [23:0] m_addr, m_raddr, m_wa;
  logic [15:0] m_din, m_wd;
  logic [7:0]  m_lo;
  logic [31:0] m_pix;
  logic [31:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   n0;
    bit   rs, ak, wack, pushd, ub0, wv0;
    if (!reset_n) begin
      m_txn = 0; m_req = 0; m_rnw = 0; m_addr = 0; m_din = 0;
      m_use = 0; m_und = 0; m_ovf = 0; m_vsp = 0; m_wv = 0;
      m_raddr = 0; m_wa = 0; m_wd = 0; m_lo = 0; m_pix = 0;
      q.delete();
      return;
    end
    rs    = ce_pix && vs && !m_vsp;
    ak    = mem_ack && (m_txn != 0);
    wack  = ak && (m_txn == 1);
    n0    = q.size();
    ub0   = m_use;
    wv0   = m_wv;
    pushd = 0;
    if (ce_pix && de && ub0) begin
      if (n0 > 0) m_pix = q.pop_front();
      else begin m_pix = 0; m_und = 1; end
    end
    if (m_txn == 0) begin
      if (wv0) begin
        m_txn = 1; m_req = 1; m_rnw = 0; m_addr = m_wa; m_din = m_wd;
      end else if (ub0 && !dl_active && (rs || n0 < DEPTH)) begin
        m_txn = 2; m_req = 1; m_rnw = 1; m_addr = rs ? 24'd0 : m_raddr;
      end
    end else if (ak) begin
      pushd = (m_txn == 2) && !rs;
      m_txn = 0; m_req = 0;
    end else if (m_txn == 2 && rs) begin
      m_txn = 3;
    end
    if (rs) begin
      q.delete();
      m_raddr = 0;
    end else if (pushd) begin
      q.push_back(mem_dout);
      m_raddr = m_raddr + 24'd2;
    end
    if (dl_wr && dl_addr[0]) begin
      if (!wv0 || wack) begin
        m_wv = 1; m_wa = dl_addr[24:1]; m_wd = {dl_data, m_lo};
      end else begin
        m_ovf = 1;
      end
    end else if (wack) begin
      m_wv = 0;
    end
    if (dl_wr && !dl_addr[0]) m_lo = dl_data;
    if (dl_wr && dl_active && sdram_present) m_use = 1;
    if (ce_pix) m_vsp = vs;
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  initial forever begin
    @(negedge clk_sys);
    if (chk_on) begin
      chk("mem_req", mem_req, m_req);
      if (m_req) begin
        chk("mem_rnw", mem_rnw, m_rnw);
        chk("mem_addr", mem_addr, m_addr);
        if (!m_rnw) chk("mem_din", mem_din, m_din);
      end
      chk("use_bg", use_bg, m_use);
      chk("pix_out", pix_out, m_pix);
      chk("underrun", underrun, m_und);
      chk("wr_overflow", wr_overflow, m_ovf);
    end
  end

  task automatic step();
    @(negedge clk_sys);
    if (!ack_en || !mem_req || mem_ack) begin
      mem_ack = 0;
      wcnt = 0;
    end else begin
      wcnt++;
      if (wcnt >= lat) begin
        mem_ack  = 1;
        mem_dout = $urandom;
        wcnt     = 0;
        if (mem_rnw) begin
          rd_a.push_back(mem_addr);
          rd_d.push_back(mem_dout);
        end
      end
    end
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
    dl_wr = 1; dl_addr = a; dl_data = d;
    step();
    dl_wr = 0;
  endtask

  task automatic wait_req(input logic v, input int lim);
    int k = 0;
    while (mem_req !== v && k < lim) begin
      step();
      k++;
    end
    chk("wait_req", mem_req, v);
  endtask

  task automatic pop_once();
    ce_pix = 1; de = 1;
    step();
    ce_pix = 0; de = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_rnw"}, mem_rnw, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_din"}, mem_din, 0);
    chk({tag, "_use"}, use_bg, 0);
    chk({tag, "_pix"}, pix_out, 0);
    chk({tag, "_und"}, underrun, 0);
    chk({tag, "_ovf"}, wr_overflow, 0);
  endtask

  initial begin
    logic [31:0] e;
    reset_n = 0; dl_active = 0; dl_wr = 0; dl_addr = 0; dl_data = 0;
    sdram_present = 1; ce_pix = 0; de = 0; vs = 0;
    mem_ack = 0; mem_dout = 0;
    step();
    chk_on = 1;
    repeat (2) step();
    chk_all_zero("reset");
    reset_n = 1;
    step();

    // packing and overflow with acks held off
    dl_active = 1;
    dl_byte(25'd0, 8'h11);
    dl_byte(25'd1, 8'h22);
    dl_byte(25'd2, 8'h33);
    dl_byte(25'd3, 8'h44);
    chk("pack_req", mem_req, 1);
    chk("pack_rnw", mem_rnw, 0);
    chk("pack_addr", mem_addr, 0);
    chk("pack_din", mem_din, 32'h2211);
    chk("pack_use", use_bg, 1);
    chk("ovf_set", wr_overflow, 1);
    repeat (4) step();
    ack_en = 1; lat = 2;
    wait_req(0, 20);
    repeat (10) step();
    chk("ovf_one_write", mem_req, 0);

    // prefetch fill
    rd_a.delete(); rd_d.delete();
    dl_active = 0; lat = 3;
    repeat (80) step();
    chk("fill_count", rd_a.size(), 8);
    foreach (rd_a[k]) chk("fill_addr", rd_a[k], 2 * k);
    chk("fill_idle", mem_req, 0);

    // pops with fast acks
    lat = 1;
    repeat (16) begin
      pop_once();
      e = (rd_d.size() > 0) ? rd_d.pop_front() : 32'hxxxxxxxx;
      chk("pop_pix", pix_out, e);
      chk("pop_und", underrun, 0);
      repeat (6) step();
    end
    ack_en = 0;
    repeat (12) begin
      pop_once();
      repeat (7) step();
    end
    chk("und_pix", pix_out, 0);
    chk("und_flag", underrun, 1);

    // restart with a read outstanding
    wait_req(1, 20);
    ce_pix = 1; vs = 1;
    step();
    ce_pix = 0;
    rd_a.delete(); rd_d.delete();
    ack_en = 1; lat = 2;
    wait_req(0, 20);
    wait_req(1, 20);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rnw", mem_rnw, 1);
    wait_req(0, 20);
    step();
    pop_once();
    e = (rd_d.size() > 1) ? rd_d[1] : 32'hxxxxxxxx;
    chk("rst_pix", pix_out, e);
    vs = 0; ce_pix = 1;
    step();
    ce_pix = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 799) != 0);
      ack_en = ($urandom_range(0, 15) != 0);
      lat = $urandom_range(1, 4);
      ce_pix = ($urandom_range(0, 3) == 0);
      de = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) vs = ~vs;
      if ($urandom_range(0, 299) == 0) dl_active = ~dl_active;
      sdram_present = ($urandom_range(0, 31) != 0);
      dl_wr = ($urandom_range(0, 2) == 0);
      dl_addr = 25'($urandom);
      dl_data = 8'($urandom);
      step();
    end
    reset_n = 1; dl_wr = 0; ce_pix = 0; de = 0;
    ack_en = 0; sdram_present = 1;
    repeat (2) step();

    // reset with a request in flight, then a late ack
    dl_active = 1;
    dl_byte(25'h100, 8'h55);
    dl_active = 0;
    wait_req(1, 20);
    reset_n = 0;
    step();
    chk_all_zero("midreq");
    reset_n = 1;
    mem_ack = 1; mem_dout = 32'hdeadbeef;
    step();
    dl_active = 1;
    dl_byte(25'h200, 8'h66);
    dl_active = 0;
    pop_once();
    chk("late_ack_pix", pix_out, 0);
    chk("late_ack_und", underrun, 1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
